// File: rtl/fifo_pkg.sv
// rtl/fifo_pkg.sv - shared widths, depths and segment-record layout for the width-converting FIFO
package fifo_pkg;

  localparam int WR_WIDTH = 16;
  localparam int RATIO    = 8;
  localparam int RD_WIDTH = WR_WIDTH * RATIO;
  localparam int DEPTH    = 512;
  localparam int WORDS    = DEPTH * RATIO;

  localparam int PTR_W  = $clog2(WORDS);
  localparam int CNT_W  = PTR_W + 1;
  localparam int BANK_W = $clog2(RATIO);
  localparam int ROW_W  = $clog2(DEPTH);

  // Clock-segment record as seen by the sequencer on dout
  localparam int ON_MSB  = 127;
  localparam int ON_LSB  = 80;
  localparam int OFF_MSB = 79;
  localparam int OFF_LSB = 32;
  localparam int REP_MSB = 31;
  localparam int REP_LSB = 0;

  typedef struct packed {
    logic [ON_MSB-ON_LSB:0]   on_counts;
    logic [OFF_MSB-OFF_LSB:0] off_counts;
    logic [REP_MSB-REP_LSB:0] repeat_counts;
  } seg_rec_t;

endpackage

// File: rtl/fifo_word_ram.sv
// rtl/fifo_word_ram.sv - word-written, entry-read storage split into RATIO banks
// Word address w lives in bank w%RATIO, row w/RATIO, so one row read yields a whole entry.
module fifo_word_ram
  import fifo_pkg::*;
(
  input  logic                clk,
  input  logic                we_i,
  input  logic [BANK_W-1:0]   wbank_i,
  input  logic [ROW_W-1:0]    wrow_i,
  input  logic [WR_WIDTH-1:0] wdata_i,
  input  logic [ROW_W-1:0]    rrow_i,
  output logic [RD_WIDTH-1:0] rdata_o
);

  for (genvar b = 0; b < RATIO; b++) begin : g_bank
    logic [WR_WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
      if (we_i && (wbank_i == BANK_W'(b))) begin
        mem[wrow_i] <= wdata_i;
      end
    end

    // Bank 0 holds the oldest word of the entry, which lands in the top slice
    assign rdata_o[RD_WIDTH-1-WR_WIDTH*b -: WR_WIDTH] = mem[rrow_i];
  end

endmodule

// File: rtl/test_fifo.sv
// rtl/test_fifo.sv - 16-bit in / 128-bit out single-clock FIFO with registered status flags
module test_fifo
  import fifo_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic [WR_WIDTH-1:0] din,
  input  logic                wr_en,
  input  logic                rd_en,
  output logic [RD_WIDTH-1:0] dout,
  output logic                empty,
  output logic                full,
  output logic                overflow,
  output logic                underflow
);

  localparam logic [CNT_W-1:0] RATIO_C = CNT_W'(RATIO);
  localparam logic [CNT_W-1:0] WORDS_C = CNT_W'(WORDS);

  logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d;
  // Read pointer kept in entries: its word address always has zero low BANK_W bits
  logic [ROW_W-1:0]    rd_row_q, rd_row_d;
  logic [CNT_W-1:0]    count_q, count_d;
  logic [RD_WIDTH-1:0] dout_q, dout_d;
  logic                empty_q, empty_d;
  logic                full_q, full_d;
  logic                overflow_q, overflow_d;
  logic                underflow_q, underflow_d;

  logic                wr_acc, rd_acc;
  logic [RD_WIDTH-1:0] ram_rdata;

  assign wr_acc = wr_en && !full_q;
  assign rd_acc = rd_en && !empty_q;

  fifo_word_ram u_ram (
    .clk     (clk),
    .we_i    (wr_acc),
    .wbank_i (wr_ptr_q[BANK_W-1:0]),
    .wrow_i  (wr_ptr_q[PTR_W-1:BANK_W]),
    .wdata_i (din),
    .rrow_i  (rd_row_q),
    .rdata_o (ram_rdata)
  );

  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    rd_row_d    = rd_row_q;
    count_d     = count_q;
    dout_d      = dout_q;
    overflow_d  = wr_en && full_q;
    underflow_d = rd_en && empty_q;

    if (wr_acc) begin
      wr_ptr_d = wr_ptr_q + PTR_W'(1);
    end
    if (rd_acc) begin
      rd_row_d = rd_row_q + ROW_W'(1);
      dout_d   = ram_rdata;
    end

    // Flags come from the start-of-cycle count, so count never under/overflows here
    case ({wr_acc, rd_acc})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - RATIO_C;
      2'b11:   count_d = count_q + CNT_W'(1) - RATIO_C;
      default: count_d = count_q;
    endcase

    empty_d = (count_d < RATIO_C);
    full_d  = (count_d == WORDS_C);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q    <= '0;
      rd_row_q    <= '0;
      count_q     <= '0;
      dout_q      <= '0;
      empty_q     <= 1'b1;
      full_q      <= 1'b0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_row_q    <= rd_row_d;
      count_q     <= count_d;
      dout_q      <= dout_d;
      empty_q     <= empty_d;
      full_q      <= full_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  assign dout      = dout_q;
  assign empty     = empty_q;
  assign full      = full_q;
  assign overflow  = overflow_q;
  assign underflow = underflow_q;

endmodule

// File: tb/tb_test_fifo.sv
// tb/tb_test_fifo.sv - directed self-checking bench for test_fifo
module tb_test_fifo;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [15:0]  din = '0;
  logic         wr_en = 1'b0;
  logic         rd_en = 1'b0;
  logic [127:0] dout;
  logic         empty, full, overflow, underflow;

  int checks = 0;
  int errors = 0;

  test_fifo dut (
    .clk       (clk),
    .rst       (rst),
    .din       (din),
    .wr_en     (wr_en),
    .rd_en     (rd_en),
    .dout      (dout),
    .empty     (empty),
    .full      (full),
    .overflow  (overflow),
    .underflow (underflow)
  );

  always #5 clk = ~clk;

  function automatic logic [127:0] entry_of(input logic [15:0] base);
    logic [127:0] e;
    for (int k = 0; k < 8; k++) e[127-16*k -: 16] = base + 16'(k);
    return e;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [15:0] d);
    wr_en = 1'b1;
    din   = d;
    tick();
    wr_en = 1'b0;
  endtask

  task automatic pop();
    rd_en = 1'b1;
    tick();
    rd_en = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    tick();
    checks++; if (empty !== 1'b1) begin errors++; $display("FAIL reset_empty: got %b want 1", empty); end
    checks++; if (full !== 1'b0) begin errors++; $display("FAIL reset_full: got %b want 0", full); end
    checks++; if (dout !== 128'h0) begin errors++; $display("FAIL reset_dout: got %h want 0", dout); end
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL reset_overflow: got %b want 0", overflow); end
    checks++; if (underflow !== 1'b0) begin errors++; $display("FAIL reset_underflow: got %b want 0", underflow); end
  endtask

  task automatic test_basic();
    for (int i = 1; i <= 8; i++) push(16'(i));
    checks++; if (empty !== 1'b0) begin errors++; $display("FAIL basic_notempty: got %b want 0", empty); end
    pop();
    checks++; if (dout !== 128'h0001_0002_0003_0004_0005_0006_0007_0008) begin
      errors++; $display("FAIL basic_dout: got %h want 00010002000300040005000600070008", dout);
    end
    checks++; if (empty !== 1'b1) begin errors++; $display("FAIL basic_empty: got %b want 1", empty); end
  endtask

  task automatic test_partial();
    for (int i = 0; i < 7; i++) push(16'h0010 + 16'(i));
    checks++; if (empty !== 1'b1) begin errors++; $display("FAIL partial_empty7: got %b want 1", empty); end
    pop();
    checks++; if (underflow !== 1'b1) begin errors++; $display("FAIL partial_underflow: got %b want 1", underflow); end
    checks++; if (dout !== 128'h0001_0002_0003_0004_0005_0006_0007_0008) begin
      errors++; $display("FAIL partial_dout_held: got %h", dout);
    end
    tick();
    checks++; if (underflow !== 1'b0) begin errors++; $display("FAIL partial_underflow_pulse: got %b want 0", underflow); end
    push(16'h0017);
    checks++; if (empty !== 1'b0) begin errors++; $display("FAIL partial_empty8: got %b want 0", empty); end
    pop();
    checks++; if (dout !== entry_of(16'h0010)) begin errors++; $display("FAIL partial_dout: got %h want %h", dout, entry_of(16'h0010)); end
  endtask

  task automatic test_full();
    for (int i = 0; i < 4096; i++) begin
      push(16'(i));
      if (i == 4094) begin
        checks++; if (full !== 1'b0) begin errors++; $display("FAIL full_at_4095: got %b want 0", full); end
      end
    end
    checks++; if (full !== 1'b1) begin errors++; $display("FAIL full_set: got %b want 1", full); end
    checks++; if (empty !== 1'b0) begin errors++; $display("FAIL full_empty: got %b want 0", empty); end
    push(16'hDEAD);
    checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL full_overflow: got %b want 1", overflow); end
    tick();
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL full_overflow_pulse: got %b want 0", overflow); end
    wr_en = 1'b1; rd_en = 1'b1; din = 16'hBEEF;
    tick();
    wr_en = 1'b0; rd_en = 1'b0;
    checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL full_rw_overflow: got %b want 1", overflow); end
    checks++; if (full !== 1'b0) begin errors++; $display("FAIL full_after_read: got %b want 0", full); end
    checks++; if (dout !== entry_of(16'h0000)) begin errors++; $display("FAIL full_first_entry: got %h want %h", dout, entry_of(16'h0000)); end
    for (int e = 1; e < 512; e++) begin
      pop();
      checks++; if (dout !== entry_of(16'(e * 8))) begin
        errors++; $display("FAIL full_drain[%0d]: got %h want %h", e, dout, entry_of(16'(e * 8)));
      end
    end
    checks++; if (empty !== 1'b1) begin errors++; $display("FAIL full_drained_empty: got %b want 1", empty); end
    pop();
    checks++; if (underflow !== 1'b1) begin errors++; $display("FAIL full_drained_underflow: got %b want 1", underflow); end
    checks++; if (dout !== entry_of(16'd4088)) begin errors++; $display("FAIL full_drained_dout: got %h want %h", dout, entry_of(16'd4088)); end
  endtask

  task automatic test_wrap();
    int next_wr = 0;
    int next_rd = 0;
    for (int e = 0; e < 4; e++) begin
      for (int k = 0; k < 8; k++) push(16'(16'h4000 + next_wr * 8 + k));
      next_wr++;
    end
    while (next_wr < 1536) begin
      for (int k = 0; k < 8; k++) begin
        wr_en = 1'b1;
        din   = 16'(16'h4000 + next_wr * 8 + k);
        rd_en = (k == 0);
        tick();
        rd_en = 1'b0;
        if (k == 0) begin
          checks++; if (dout !== entry_of(16'(16'h4000 + next_rd * 8))) begin
            errors++; $display("FAIL wrap_dout[%0d]: got %h want %h", next_rd, dout, entry_of(16'(16'h4000 + next_rd * 8)));
          end
          next_rd++;
        end
        checks++; if (empty !== 1'b0 || full !== 1'b0) begin
          errors++; $display("FAIL wrap_flags[%0d]: got empty=%b full=%b want 0 0", next_wr, empty, full);
        end
      end
      wr_en = 1'b0;
      next_wr++;
    end
    while (next_rd < 1536) begin
      pop();
      checks++; if (dout !== entry_of(16'(16'h4000 + next_rd * 8))) begin
        errors++; $display("FAIL wrap_drain[%0d]: got %h want %h", next_rd, dout, entry_of(16'(16'h4000 + next_rd * 8)));
      end
      next_rd++;
    end
    checks++; if (empty !== 1'b1) begin errors++; $display("FAIL wrap_empty: got %b want 1", empty); end
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 43; i++) push(16'h5000 + 16'(i));
    #2;
    rst = 1'b1;
    #1;
    checks++; if (empty !== 1'b1) begin errors++; $display("FAIL midrst_empty: got %b want 1", empty); end
    checks++; if (dout !== 128'h0) begin errors++; $display("FAIL midrst_dout: got %h want 0", dout); end
    checks++; if (full !== 1'b0) begin errors++; $display("FAIL midrst_full: got %b want 0", full); end
    tick();
    rst = 1'b0;
    for (int i = 0; i < 7; i++) push(16'hA000 + 16'(i));
    checks++; if (empty !== 1'b1) begin errors++; $display("FAIL midrst_partial_discarded: got %b want 1", empty); end
    push(16'hA007);
    pop();
    checks++; if (dout !== entry_of(16'hA000)) begin errors++; $display("FAIL midrst_dout_new: got %h want %h", dout, entry_of(16'hA000)); end
    checks++; if (empty !== 1'b1) begin errors++; $display("FAIL midrst_empty_after: got %b want 1", empty); end
    checks++; if (underflow !== 1'b0) begin errors++; $display("FAIL midrst_underflow: got %b want 0", underflow); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_partial();
    test_full();
    test_wrap();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
